// File: rtl/cpu_debug_pkg.sv
// Shared debug-trace definitions: trace FSM encodings, word index
// constants and the control-FSM fetch state code.
package cpu_debug_pkg;

  typedef enum logic [1:0] {
    TS_IDLE    = 2'd0,
    TS_ARMED   = 2'd1,
    TS_CAPTURE = 2'd2,
    TS_DONE    = 2'd3
  } trace_state_t;

  localparam logic [1:0] IDX_PC   = 2'd0;
  localparam logic [1:0] IDX_MSP  = 2'd1;
  localparam logic [1:0] IDX_RSP  = 2'd2;
  localparam logic [1:0] IDX_VALA = 2'd3;

  localparam logic [4:0] FETCH_STATE = 5'd0;

  // Value that can never be the fetch state, so the first
  // fetch after reset is seen as an entry.
  localparam logic [4:0] PREV_RESET = 5'h1F;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] msp;
    logic [15:0] rsp;
    logic [15:0] vala;
  } trace_entry_t;

endpackage

// File: rtl/cpu_trace_capture_fifo.sv
// trace_fifo: synchronous FIFO, power-of-two DEPTH, async reset, flush.
// Ports: i_clk, i_rst, i_flush, i_push/i_data, i_pop, o_data (head),
//        o_full, o_empty, o_count.
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == DEPTH[AW:0]);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// Passive CPU trace observer: snapshots PC/MSP/RSP/ValA on each fetch
// entry into a FIFO under an arm/trigger/limit FSM.
// Ports: CPU debug inputs (CurrentState, PCOut, MSPOut, RSPOut, ValAOut),
//        control (Arm, Clear, TrigEn, TrigPC, Limit), 16-bit word reader
//        (RdData, RdValid, RdLast, RdReady), status (TraceState,
//        Overflow, Count, Captured).
module cpu_trace_capture
  import cpu_debug_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter logic [4:0] FETCH_STATE = cpu_debug_pkg::FETCH_STATE
) (
  input  logic                   CLK,
  input  logic                   Rst,
  input  logic [4:0]             CurrentState,
  input  logic [15:0]            PCOut,
  input  logic [15:0]            MSPOut,
  input  logic [15:0]            RSPOut,
  input  logic [15:0]            ValAOut,
  input  logic                   Arm,
  input  logic                   Clear,
  input  logic                   TrigEn,
  input  logic [15:0]            TrigPC,
  input  logic [7:0]             Limit,
  output logic [15:0]            RdData,
  output logic                   RdValid,
  output logic                   RdLast,
  input  logic                   RdReady,
  output logic [1:0]             TraceState,
  output logic                   Overflow,
  output logic [$clog2(DEPTH):0] Count,
  output logic [7:0]             Captured
);

  trace_state_t r_state;
  trace_state_t w_next_state;
  logic [4:0]   r_prev_state;
  logic [7:0]   r_captured;
  logic         r_overflow;
  logic [1:0]   r_idx;

  logic         w_fe;
  logic         w_trig_hit;
  logic         w_wr_req;
  logic         w_push;
  logic         w_pop;
  logic         w_xfer;
  logic         w_full;
  logic         w_empty;
  logic         w_limit_hit;
  logic         w_arm_restart;
  logic [7:0]   w_cap_next;
  trace_entry_t w_snap;
  trace_entry_t w_head;

  assign w_fe = (CurrentState == FETCH_STATE)
             && (r_prev_state != FETCH_STATE);

  assign w_trig_hit = !TrigEn || (PCOut == TrigPC);

  assign w_wr_req = !Clear && w_fe
                 && (((r_state == TS_ARMED) && w_trig_hit)
                  || (r_state == TS_CAPTURE));

  assign w_xfer = RdValid && RdReady && !Clear;
  assign w_pop  = w_xfer && (r_idx == IDX_VALA);
  assign w_push = w_wr_req && (!w_full || w_pop);

  assign w_cap_next = (r_captured == 8'hFF) ? 8'hFF
                                            : r_captured + 8'd1;

  // The limit applies to the triggering entry too, so Limit=1 stops
  // after exactly one entry.
  assign w_limit_hit = w_push && (Limit != 8'd0)
                    && (({1'b0, r_captured} + 9'd1) == {1'b0, Limit});

  assign w_arm_restart = Arm
                      && ((r_state == TS_IDLE) || (r_state == TS_DONE));

  assign w_snap = '{pc: PCOut, msp: MSPOut,
                    rsp: RSPOut, vala: ValAOut};

  trace_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (Rst),
    .i_flush (Clear),
    .i_push  (w_push),
    .i_data  (w_snap),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (Count)
  );

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      r_state <= TS_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (Clear) begin
      w_next_state = TS_IDLE;
    end else begin
      unique case (r_state)
        TS_IDLE: begin
          if (Arm) w_next_state = TS_ARMED;
        end
        TS_ARMED: begin
          if (w_wr_req) begin
            w_next_state = w_limit_hit ? TS_DONE : TS_CAPTURE;
          end
        end
        TS_CAPTURE: begin
          if (w_limit_hit) w_next_state = TS_DONE;
        end
        TS_DONE: begin
          if (Arm) w_next_state = TS_ARMED;
        end
        default: w_next_state = TS_IDLE;
      endcase
    end
  end

  always_comb begin
    TraceState = r_state;
    RdValid    = !w_empty;
    RdLast     = RdValid && (r_idx == IDX_VALA);
    Overflow   = r_overflow;
    Captured   = r_captured;
    RdData     = 16'h0000;
    if (RdValid) begin
      unique case (r_idx)
        IDX_PC:   RdData = w_head.pc;
        IDX_MSP:  RdData = w_head.msp;
        IDX_RSP:  RdData = w_head.rsp;
        IDX_VALA: RdData = w_head.vala;
        default:  RdData = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      r_prev_state <= PREV_RESET;
    end else begin
      r_prev_state <= CurrentState;
    end
  end

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      r_captured <= 8'd0;
      r_overflow <= 1'b0;
      r_idx      <= IDX_PC;
    end else if (Clear) begin
      r_captured <= 8'd0;
      r_overflow <= 1'b0;
      r_idx      <= IDX_PC;
    end else begin
      if (w_arm_restart) begin
        r_captured <= 8'd0;
      end else if (w_push) begin
        r_captured <= w_cap_next;
      end
      if (Arm && (r_state == TS_DONE)) begin
        r_overflow <= 1'b0;
      end else if (w_wr_req && !w_push) begin
        r_overflow <= 1'b1;
      end
      // idx3 + 1 wraps to idx0, matching the pop of the entry.
      if (w_xfer) r_idx <= r_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Self-checking bench for cpu_trace_capture: scoreboard of expected
// trace words, one task per scenario.
module tb_cpu_trace_capture;

  logic        CLK;
  logic        Rst;
  logic [4:0]  CurrentState;
  logic [15:0] PCOut, MSPOut, RSPOut, ValAOut;
  logic        Arm, Clear, TrigEn;
  logic [15:0] TrigPC;
  logic [7:0]  Limit;
  logic [15:0] RdData;
  logic        RdValid, RdLast, RdReady;
  logic [1:0]  TraceState;
  logic        Overflow;
  logic [4:0]  Count;
  logic [7:0]  Captured;

  int vectors = 0;
  int miscompares = 0;

  logic [16:0] q[$];

  cpu_trace_capture #(.DEPTH(16), .FETCH_STATE(5'd0)) dut (
    .CLK(CLK), .Rst(Rst), .CurrentState(CurrentState),
    .PCOut(PCOut), .MSPOut(MSPOut), .RSPOut(RSPOut),
    .ValAOut(ValAOut), .Arm(Arm), .Clear(Clear),
    .TrigEn(TrigEn), .TrigPC(TrigPC), .Limit(Limit),
    .RdData(RdData), .RdValid(RdValid), .RdLast(RdLast),
    .RdReady(RdReady), .TraceState(TraceState),
    .Overflow(Overflow), .Count(Count), .Captured(Captured)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_entry(input logic [15:0] pc, msp, rsp, va);
    q.push_back({1'b0, pc});
    q.push_back({1'b0, msp});
    q.push_back({1'b0, rsp});
    q.push_back({1'b1, va});
  endtask

  // One fetch entry: non-fetch cycle, fetch cycle with data, back out.
  task automatic fe(input logic [15:0] pc, msp, rsp, va,
                    input bit wr);
    CurrentState = 5'd3;
    @(negedge CLK);
    CurrentState = 5'd0;
    PCOut = pc; MSPOut = msp; RSPOut = rsp; ValAOut = va;
    if (wr) push_entry(pc, msp, rsp, va);
    @(negedge CLK);
    CurrentState = 5'd3;
    PCOut = 16'hDEAD; MSPOut = 16'hBEEF;
    RSPOut = 16'hCAFE; ValAOut = 16'hF00D;
  endtask

  task automatic arm_pulse();
    Arm = 1'b1;
    @(negedge CLK);
    Arm = 1'b0;
  endtask

  task automatic clear_pulse();
    Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0;
    q.delete();
  endtask

  task automatic drain(input int budget);
    logic [16:0] exp;
    RdReady = 1'b1;
    while (q.size() != 0 && budget > 0) begin
      if (RdValid) begin
        exp = q.pop_front();
        vectors++;
        if ({RdLast, RdData} !== exp) begin
          miscompares++;
          $display("FAIL drain_word: got last=%b data=%h, want last=%b data=%h",
                   RdLast, RdData, exp[16], exp[15:0]);
        end
      end
      budget--;
      @(negedge CLK);
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d words left, want 0", q.size());
      q.delete();
    end
    RdReady = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if ({TraceState, Count, Captured, Overflow, RdValid, RdLast, RdData}
        !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ts=%0d cnt=%0d cap=%0d ovf=%b v=%b l=%b d=%h, want all 0",
               TraceState, Count, Captured, Overflow, RdValid, RdLast, RdData);
    end
    Rst = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    TrigEn = 1'b0; Limit = 8'd0;
    arm_pulse();
    vectors++;
    if (TraceState !== 2'd1) begin
      miscompares++;
      $display("FAIL basic_armed: got %0d, want 1", TraceState);
    end
    fe(16'h0010, 16'h7FF0, 16'h7EF0, 16'h1234, 1'b1);
    vectors++;
    if (RdValid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency: got RdValid=%b, want 1", RdValid);
    end
    drain(4);
    vectors++;
    if (Count !== 5'd0) begin
      miscompares++;
      $display("FAIL basic_count: got %0d, want 0", Count);
    end
  endtask

  task automatic test_trigger_limit();
    clear_pulse();
    TrigEn = 1'b1; TrigPC = 16'h0040; Limit = 8'd3;
    arm_pulse();
    fe(16'h0030, 16'h1030, 16'h2030, 16'h3030, 1'b0);
    vectors++;
    if (TraceState !== 2'd1 || Count !== 5'd0) begin
      miscompares++;
      $display("FAIL trig_skip: got ts=%0d cnt=%0d, want ts=1 cnt=0",
               TraceState, Count);
    end
    fe(16'h0040, 16'h1040, 16'h2040, 16'h3040, 1'b1);
    fe(16'h0042, 16'h1042, 16'h2042, 16'h3042, 1'b1);
    vectors++;
    if (TraceState !== 2'd2) begin
      miscompares++;
      $display("FAIL trig_capture: got ts=%0d, want 2", TraceState);
    end
    fe(16'h0044, 16'h1044, 16'h2044, 16'h3044, 1'b1);
    vectors++;
    if (TraceState !== 2'd3 || Captured !== 8'd3) begin
      miscompares++;
      $display("FAIL trig_done: got ts=%0d cap=%0d, want ts=3 cap=3",
               TraceState, Captured);
    end
    fe(16'h0046, 16'h1046, 16'h2046, 16'h3046, 1'b0);
    vectors++;
    if (Count !== 5'd3 || Captured !== 8'd3) begin
      miscompares++;
      $display("FAIL trig_after_done: got cnt=%0d cap=%0d, want 3/3",
               Count, Captured);
    end
    drain(12);
    TrigEn = 1'b0; Limit = 8'd0;
  endtask

  task automatic test_hold_fetch();
    clear_pulse();
    arm_pulse();
    CurrentState = 5'd3;
    @(negedge CLK);
    CurrentState = 5'd0;
    PCOut = 16'h0100; MSPOut = 16'h1100;
    RSPOut = 16'h2100; ValAOut = 16'h3100;
    push_entry(16'h0100, 16'h1100, 16'h2100, 16'h3100);
    @(negedge CLK);
    for (int i = 1; i < 5; i++) begin
      PCOut = 16'h0100 + 16'(i); ValAOut = 16'h5500 + 16'(i);
      @(negedge CLK);
    end
    CurrentState = 5'd2;
    @(negedge CLK);
    CurrentState = 5'd0;
    PCOut = 16'h0200; MSPOut = 16'h1200;
    RSPOut = 16'h2200; ValAOut = 16'h3200;
    push_entry(16'h0200, 16'h1200, 16'h2200, 16'h3200);
    @(negedge CLK);
    CurrentState = 5'd3;
    @(negedge CLK);
    vectors++;
    if (Count !== 5'd2 || Captured !== 8'd2) begin
      miscompares++;
      $display("FAIL hold_fetch: got cnt=%0d cap=%0d, want 2/2",
               Count, Captured);
    end
    drain(8);
  endtask

  task automatic test_overflow();
    clear_pulse();
    arm_pulse();
    RdReady = 1'b0;
    for (int i = 0; i < 18; i++) begin
      fe(16'h1000 + 16'(i), 16'h7000 - 16'(i),
         16'h6000 + 16'(i * 3), 16'hA000 ^ 16'(i * 7), i < 16);
    end
    vectors++;
    if (Count !== 5'd16 || Overflow !== 1'b1 || Captured !== 8'd16) begin
      miscompares++;
      $display("FAIL overflow_status: got cnt=%0d ovf=%b cap=%0d, want 16/1/16",
               Count, Overflow, Captured);
    end
    drain(64);
  endtask

  task automatic test_back_to_back_stall();
    logic [16:0] exp;
    clear_pulse();
    arm_pulse();
    fe(16'h0300, 16'h1300, 16'h2300, 16'h3300, 1'b1);
    RdReady = 1'b1;
    for (int w = 0; w < 2; w++) begin
      exp = q.pop_front();
      vectors++;
      if ({RdLast, RdData} !== exp) begin
        miscompares++;
        $display("FAIL stall_pre%0d: got l=%b d=%h, want l=%b d=%h",
                 w, RdLast, RdData, exp[16], exp[15:0]);
      end
      @(negedge CLK);
    end
    RdReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({RdLast, RdData} !== {1'b0, 16'h2300} || RdValid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got v=%b l=%b d=%h, want v=1 l=0 d=2300",
                 c, RdValid, RdLast, RdData);
      end
      @(negedge CLK);
    end
    drain(2);
    vectors++;
    if (Count !== 5'd0) begin
      miscompares++;
      $display("FAIL stall_count: got %0d, want 0", Count);
    end
  endtask

  task automatic test_reset_mid();
    clear_pulse();
    arm_pulse();
    fe(16'h0400, 16'h1400, 16'h2400, 16'h3400, 1'b1);
    fe(16'h0402, 16'h1402, 16'h2402, 16'h3402, 1'b1);
    RdReady = 1'b1;
    @(negedge CLK);
    #2 Rst = 1'b1;
    #1;
    vectors++;
    if ({TraceState, Count, Captured, Overflow, RdValid, RdLast, RdData}
        !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got ts=%0d cnt=%0d cap=%0d ovf=%b v=%b l=%b d=%h, want all 0",
               TraceState, Count, Captured, Overflow, RdValid, RdLast, RdData);
    end
    RdReady = 1'b0;
    q.delete();
    @(negedge CLK);
    Rst = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_clear_capture();
    arm_pulse();
    for (int i = 0; i < 17; i++) begin
      fe(16'h0500 + 16'(i), 16'h1500, 16'h2500, 16'h3500, 1'b0);
    end
    vectors++;
    if (TraceState !== 2'd2 || Overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_pre: got ts=%0d ovf=%b, want 2/1",
               TraceState, Overflow);
    end
    Clear = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({TraceState, Count, Captured, Overflow, RdValid, RdLast, RdData}
        !== 35'd0) begin
      miscompares++;
      $display("FAIL clear_capture: got ts=%0d cnt=%0d cap=%0d ovf=%b v=%b l=%b d=%h, want all 0",
               TraceState, Count, Captured, Overflow, RdValid, RdLast, RdData);
    end
    Clear = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    Rst = 1'b1; CurrentState = 5'd3;
    PCOut = '0; MSPOut = '0; RSPOut = '0; ValAOut = '0;
    Arm = 1'b0; Clear = 1'b0; TrigEn = 1'b0;
    TrigPC = '0; Limit = '0; RdReady = 1'b0;
    test_reset();
    test_basic();
    test_trigger_limit();
    test_hold_fetch();
    test_overflow();
    test_back_to_back_stall();
    test_reset_mid();
    test_clear_capture();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_trace_capture.md
Name: cpu_trace_capture

Overview:
- Passive debug observer: the consuming end of the CPU's debug outputs (CurrentState, PCOut, MSPOut, RSPOut, ValAOut).
- On every entry into the fetch state it snapshots the four 16-bit datapath values into a trace FIFO, gated by an arm/trigger/limit state machine.
- A host-side reader drains the FIFO as 16-bit words over a valid/ready handshake.
- Sits beside the full-integration top level; it never drives any CPU signal.

Parameters:
- DEPTH, 16, FIFO depth in entries; each entry is 64 bits. Power of two, minimum 2.
- FETCH_STATE, 5'd0, control-FSM state code that marks instruction fetch. Must not equal 5'h1F.

Ports:
- CLK  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- CurrentState  in  5  control-FSM current state.
- PCOut  in  16  program counter.
- MSPOut  in  16  main stack pointer.
- RSPOut  in  16  return stack pointer.
- ValAOut  in  16  ValA register.
- Arm  in  1  start a capture (level, sampled each cycle).
- Clear  in  1  flush FIFO, clear status, return to IDLE.
- TrigEn  in  1  1 = wait for a PC match; 0 = trigger on the first fetch entry.
- TrigPC  in  16  trigger PC value.
- Limit  in  8  entries to capture after the trigger; 0 = unlimited.
- RdData  out  16  trace word.
- RdValid  out  1  RdData is valid.
- RdLast  out  1  current word is the last word (word 3) of an entry.
- RdReady  in  1  reader accepts the word.
- TraceState  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- Overflow  out  1  sticky: an entry was dropped.
- Count  out  $clog2(DEPTH)+1  entries held in the FIFO.
- Captured  out  8  entries written since the last Arm.

Behaviour:
- Reset: TraceState=IDLE; FIFO empty; Count=0; Captured=0; Overflow=0; RdValid=0; RdLast=0; RdData=0; word index=0; PrevState=5'h1F.
- Fetch-entry event (FE):
  - FE = (CurrentState==FETCH_STATE) && (PrevState!=FETCH_STATE).
  - PrevState registers CurrentState every cycle.
  - A state held at FETCH for several cycles produces one FE.
- Snapshot: {PCOut, MSPOut, RSPOut, ValAOut} sampled in the FE cycle.
- FSM (Clear has priority over everything; Clear in any state -> IDLE, FIFO flushed, Overflow=0, Captured=0, word index=0):
  - IDLE: Arm -> ARMED, Captured=0.
  - ARMED: FE with (!TrigEn || PCOut==TrigPC) -> CAPTURE; that FE entry is written.
  - CAPTURE: each FE writes an entry. After a write with Limit!=0 and Captured+1==Limit -> DONE.
  - DONE: Arm -> ARMED, Captured=0, Overflow=0; FIFO contents are kept.
  - Arm in ARMED or CAPTURE is ignored.
- Write acceptance: an entry is written if Count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped, Overflow=1, and Captured does not increment.
  - Captured saturates at 255.
- Latency: an entry written at the end of the FE cycle N is presented on RdData with RdValid=1 from cycle N+1 (FIFO previously empty).
- Readout:
  - Each entry is emitted as 4 words in order: PC (idx0), MSP (idx1), RSP (idx2), ValA (idx3).
  - RdLast = (idx==3) && RdValid.
  - A word transfers on RdValid && RdReady; idx then advances. A transfer at idx3 pops the entry and resets idx to 0.
  - RdData/RdLast are stable while RdValid && !RdReady.
  - RdValid = (Count!=0). Combinational read from FIFO storage is permitted.
- Count: +1 on write, -1 on pop, unchanged when both occur. Read and write pointers wrap modulo DEPTH.
- Reset mid-operation: immediate return to the reset values; any partially read entry is lost.

Decomposition:
- Shared package cpu_debug_pkg holds:
  - the TraceState encodings (TS_IDLE=0, TS_ARMED=1, TS_CAPTURE=2, TS_DONE=3);
  - the trace word index constants;
  - FETCH_STATE, mirrored from the control-FSM state encoding.
- One sub-module, trace_fifo: a parameterised synchronous FIFO (width 64, DEPTH) with push, pop, full, empty, count and async reset. The FSM, edge detect and word serializer stay in the parent.

Test Plan:
- Reset, then TrigEn=0 and Arm pulse. Drive state 3 -> 0 (FE) with PC=0x0010, MSP=0x7FF0, RSP=0x7EF0, ValA=0x1234. -> RdValid in the next cycle; with RdReady=1, words 0x0010, 0x7FF0, 0x7EF0, 0x1234 in 4 consecutive cycles; RdLast only on 0x1234; Count back to 0.
- TrigEn=1, TrigPC=0x0040, Limit=3. FEs at PC 0x0030, 0x0040, 0x0042, 0x0044, 0x0046. -> 0x0030 skipped; 3 entries captured; DONE after 0x0044; Captured=3; 0x0046 not captured.
- CurrentState held at 0 for 5 cycles, then 2, then 0. -> exactly 2 entries written.
- DEPTH=16, RdReady=0, Limit=0, 18 FEs. -> Count=16, Overflow=1, Captured=16. Then drain all entries -> 64 words match the first 16 snapshots in order.
- Hold RdReady=0 mid-entry at idx2 for 3 cycles. -> RdData=RSP value stable and RdLast=0; on release, the sequence resumes with no word skipped or repeated.
- Rst asserted asynchronously mid-readout, then Clear during CAPTURE (separate runs). -> all outputs return to reset values; TraceState=IDLE; Count=0; Overflow=0.
